// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//
// Byte-serial SHA-256 message padder. Collects message bytes into a 512-bit
// block buffer, appends the 0x80 marker, zero fill and the 64-bit big-endian
// bit length, and hands complete blocks to the chaining controller.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_valid         i_data / i_last are valid
//   i_data [7:0]    message byte
//   i_last          current byte is the final message byte
//   o_in_ready      a byte can be accepted this cycle (FILL state)
//   o_block [511:0] block; byte 0 in [511:504], byte 63 in [7:0]
//   o_block_valid   o_block holds a complete block
//   o_block_last    o_block is the final padded block of the message
//   i_block_ready   consumer takes the block on this edge
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [7:0]   i_data,
  input  logic         i_last,
  output logic         o_in_ready,
  output logic [511:0] o_block,
  output logic         o_block_valid,
  output logic         o_block_last,
  input  logic         i_block_ready
);

  typedef enum logic [1:0] {FILL, EMIT, EMIT_TAIL} state_t;

  state_t             state;
  state_t             state_next;
  logic [511:0]       blk;
  logic [5:0]         idx;
  logic [LEN_W-1:0]   byte_cnt;
  logic               last_q;        // block on the output is the final one
  logic               tail_pending;  // a length-only tail block follows
  logic               tail_marker;   // tail block starts with 0x80 (k = 63)

  logic               accept;
  logic               handshake;
  logic [LEN_W-1:0]   cnt_inc;
  logic [511:0]       ins;
  logic [511:0]       fill_blk;
  logic [511:0]       tail_blk;

  // Message bit length, zero-extended to 64 bits.
  function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] n);
    return 64'({n, 3'b000});
  endfunction

  assign accept        = i_valid && (state == FILL);
  assign handshake     = i_block_ready && (state != FILL);
  assign cnt_inc       = byte_cnt + LEN_W'(1);
  assign o_in_ready    = (state == FILL);
  assign o_block_valid = (state != FILL);
  assign o_block       = blk;
  assign o_block_last  = last_q;

  // The byte and (for the last byte) its 0x80 marker are placed together by
  // one shift. Every byte above idx is already zero, so OR-ing is enough;
  // at idx = 63 the marker falls off the end and goes to the tail block.
  assign ins = {i_data, (i_last ? 8'h80 : 8'h00), 496'b0} >> {idx, 3'b000};

  assign tail_blk = {(tail_marker ? 8'h80 : 8'h00), 440'b0, bit_len(byte_cnt)};

  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    fill_blk = blk | ins;
    if (i_last && idx <= 6'd54) fill_blk[63:0] = bit_len(cnt_inc);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:      if (accept && (i_last || idx == 6'd63)) state_next = EMIT;
      EMIT:      if (i_block_ready)
                   state_next = (!last_q && tail_pending) ? EMIT_TAIL : FILL;
      EMIT_TAIL: if (i_block_ready) state_next = FILL;
      default:   state_next = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // NOTE: the block buffer is a plain 512-bit register, not a RAM, so it is
  // reset along with the control state; the zero-above-idx invariant that
  // the fill logic relies on depends on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk          <= '0;
      idx          <= '0;
      byte_cnt     <= '0;
      last_q       <= 1'b0;
      tail_pending <= 1'b0;
      tail_marker  <= 1'b0;
    end else if (accept) begin
      blk      <= fill_blk;
      idx      <= idx + 6'd1;
      byte_cnt <= cnt_inc;
      if (i_last) begin
        last_q       <= (idx <= 6'd54);
        tail_pending <= (idx > 6'd54);
        tail_marker  <= (idx == 6'd63);
      end
    end else if (handshake) begin
      if (last_q) begin
        // Final block taken: start a fresh message.
        blk          <= '0;
        idx          <= '0;
        byte_cnt     <= '0;
        last_q       <= 1'b0;
        tail_pending <= 1'b0;
        tail_marker  <= 1'b0;
      end else if (tail_pending) begin
        // Length did not fit: present the tail block next cycle.
        blk          <= tail_blk;
        last_q       <= 1'b1;
        tail_pending <= 1'b0;
      end else begin
        // Full data block taken mid-message; byte_cnt keeps running.
        blk <= '0;
        idx <= '0;
      end
    end
  end

endmodule
